// File: rtl/capture_pkg.sv
// capture_pkg: shared types and constants for the sample-RAM write side.
//   cap_state_t       - capture FSM states
//   CAP_LEN_FULL_CODE - len encoding that requests a full-depth capture
//   cap_full_count()  - sample count of a full-depth capture for a given address width
package capture_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} cap_state_t;

    // A programmed len of this value means "fill the whole RAM" (2^A_WIDTH samples).
    localparam int unsigned CAP_LEN_FULL_CODE = 0;

    function automatic int unsigned cap_full_count(input int unsigned a_width);
        return 32'd1 << a_width;
    endfunction

endpackage

// File: rtl/addr_step_counter.sv
// addr_step_counter: registered RAM address with synchronous load and stepping.
//   clk     - clock
//   rst     - asynchronous active-low reset, clears addr
//   load    - load base into addr (wins over step_en)
//   step_en - advance addr by step, wrapping modulo 2^WIDTH
//   base    - load value
//   step    - increment
//   addr    - current address
module addr_step_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step_en,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] addr
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr <= '0;
        end else if (load) begin
            addr <= base;
        end else if (step_en) begin
            addr <= addr + step;
        end
    end

endmodule

// File: rtl/capture_writer.sv
// capture_writer: triggered capture of a sample stream into a 2^A_WIDTH-deep RAM.
//   clk, rst            - clock, asynchronous active-low reset
//   en                  - global enable; low freezes state and drops in_ready
//   arm, abort, trig    - start request (IDLE only), return to IDLE, capture trigger
//   base, incr, len     - first address, address step, sample count (0 = full depth)
//   in_valid, in_data   - sample stream; in_ready accepts it
//   wr_en/addr/data     - registered RAM write port
//   busy, done          - ARMED/CAPTURE flag, one-cycle completion pulse
module capture_writer
    import capture_pkg::*;
#(
    parameter int unsigned A_WIDTH = 8,
    parameter int unsigned D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               arm,
    input  logic               abort,
    input  logic               trig,
    input  logic [A_WIDTH-1:0] base,
    input  logic [A_WIDTH-1:0] incr,
    input  logic [A_WIDTH-1:0] len,
    input  logic               in_valid,
    input  logic [D_WIDTH-1:0] in_data,
    output logic               in_ready,
    output logic               wr_en,
    output logic [A_WIDTH-1:0] wr_addr,
    output logic [D_WIDTH-1:0] wr_data,
    output logic               busy,
    output logic               done
);

    localparam logic [A_WIDTH-1:0] LEN_FULL   = A_WIDTH'(CAP_LEN_FULL_CODE);
    localparam logic [A_WIDTH:0]   FULL_COUNT = (A_WIDTH+1)'(cap_full_count(A_WIDTH));
    localparam logic [A_WIDTH:0]   REM_ONE    = {{A_WIDTH{1'b0}}, 1'b1};

    cap_state_t         state_q;
    logic [A_WIDTH-1:0] step_q;
    logic [A_WIDTH:0]   rem_q;
    logic [A_WIDTH-1:0] addr;

    logic handshake;
    logic take;
    logic start;
    logic last;

    assign in_ready  = en && (state_q == ARMED || state_q == CAPTURE);
    assign handshake = in_valid && in_ready;
    // In ARMED only the triggering sample is kept; earlier ones are discarded.
    assign take      = handshake && (state_q == CAPTURE || (state_q == ARMED && trig));
    assign start     = (state_q == IDLE) && arm && en;
    assign last      = (rem_q == REM_ONE);

    addr_step_counter #(
        .WIDTH (A_WIDTH)
    ) u_addr (
        .clk     (clk),
        .rst     (rst),
        .load    (start && !abort),
        .step_en (take && !abort),
        .base    (base),
        .step    (step_q),
        .addr    (addr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            rem_q   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
                busy    <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q <= ARMED;
                            busy    <= 1'b1;
                            step_q  <= incr;
                            rem_q   <= (len == LEN_FULL) ? FULL_COUNT : {1'b0, len};
                        end
                    end
                    ARMED, CAPTURE: begin
                        if (take) begin
                            wr_en   <= 1'b1;
                            wr_addr <= addr;
                            wr_data <= in_data;
                            rem_q   <= rem_q - REM_ONE;
                            if (last) begin
                                state_q <= DONE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                state_q <= CAPTURE;
                            end
                        end
                    end
                    DONE: state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/capture_writer.md
# capture_writer

Write-side address generator for the signal-generator sample RAM: the counterpart of the read-address counter that sweeps waveform memory. It accepts a stream of samples over a valid/ready handshake, waits for a trigger, then writes a programmed number of samples into a 2^A_WIDTH-deep RAM. Writes start at a base address and advance by a programmable step, wrapping modulo 2^A_WIDTH. The read side later sweeps the same RAM with its own increment and offset.

## Interface
- A_WIDTH, 8, RAM address width; RAM depth is 2^A_WIDTH.
- D_WIDTH, 8, sample width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  global enable; low freezes all state and drops in_ready.
- arm  in  1  start request; sampled only in IDLE.
- abort  in  1  return to IDLE; highest priority.
- trig  in  1  capture trigger; qualified by in_valid.
- base  in  A_WIDTH  first write address, latched on arm.
- incr  in  A_WIDTH  address step, latched on arm.
- len  in  A_WIDTH  samples to write, latched on arm; 0 means 2^A_WIDTH.
- in_valid  in  1  sample present.
- in_data  in  D_WIDTH  sample value.
- in_ready  out  1  sample accepted this cycle when in_valid is also high.
- wr_en  out  1  RAM write strobe (registered).
- wr_addr  out  A_WIDTH  RAM write address (registered).
- wr_data  out  D_WIDTH  RAM write data (registered).
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  one-cycle pulse when the capture completes.

## Operation
- States: IDLE, ARMED, CAPTURE, DONE.
- A handshake is `in_valid && in_ready`.
- in_ready is combinational: `en && (state==ARMED || state==CAPTURE)`.
- IDLE:
  - arm=1 and en=1 → ARMED.
  - On the same edge, latch base into the address register, incr into the step register, and len into the remaining counter (0 loads 2^A_WIDTH).
- ARMED:
  - A handshake with trig=0 discards the sample.
  - A handshake with trig=1 writes that sample at base. The remaining count decrements and the address becomes base+incr.
  - If remaining reaches 0 → DONE, otherwise → CAPTURE.
  - trig without in_valid is ignored.
- CAPTURE:
  - Each handshake writes at the current address, then address += incr (mod 2^A_WIDTH) and remaining -= 1.
  - When remaining reaches 0 → DONE.
  - trig is ignored.
- DONE: lasts exactly one cycle with done=1, then → IDLE. The en level is irrelevant in DONE.
- abort=1 (with any en level) → IDLE on the next edge.
  - No done pulse.
  - Writes already registered still complete.
  - abort outranks arm, trig and completion in the same cycle.
- arm is ignored outside IDLE.
- Address arithmetic is unsigned, A_WIDTH bits, and wraps silently; incr=0 rewrites a single address.
- Remaining counter is A_WIDTH+1 bits.
- Reset values:
  - state=IDLE.
  - wr_en=0, wr_addr=0, wr_data=0.
  - done=0, busy=0.
  - Internal address, step and remaining registers = 0.

## Timing
- Write latency: a handshake at edge k gives wr_en=1 with the matching wr_addr/wr_data in the cycle after edge k. wr_en is otherwise 0.
- Throughput: one sample per cycle, sustained.
- State timing:
  - busy rises the cycle after the arm edge.
  - done is high in the cycle following the final handshake, i.e. coincident with the final wr_en.
  - busy falls in that same cycle.
- en=0 in ARMED/CAPTURE: no handshakes, and state, address and remaining hold. wr_en is 0 in the following cycle.
- An asynchronous rst assertion mid-capture immediately forces the reset values. Partial RAM contents are left as written.

## Structure
- Shared package `capture_pkg`:
  - State enum `cap_state_t` {IDLE, ARMED, CAPTURE, DONE}.
  - Localparam for the len=0 → 2^A_WIDTH conversion.
- One sub-module: `addr_step_counter`, a registered address with synchronous load (base), step-enable (add incr) and an async active-low reset. The read side's address generator uses the same block.
- Top level holds the FSM, the remaining counter and the output registers.

## Test plan
- Basic capture: base=0x10, incr=1, len=4; arm; stream 0xA0..0xA7 with trig on 0xA2 → writes 0xA2..0xA5 to 0x10..0x13; done pulses once with the last write; in_ready=0 afterwards.
- Wrap and step: base=0xFE, incr=3, len=3 → addresses 0xFE, 0x01, 0x04.
- Back-pressure and gaps: toggle en and in_valid during CAPTURE, len=5 → exactly 5 writes, in order, with no address skips.
- Full-depth capture: len=0 → exactly 256 writes before done.
- Single-sample capture: len=1 → one write at base; FSM goes from ARMED straight to DONE.
- Abort and reset:
  - abort with trig in ARMED → no write, no done.
  - abort in CAPTURE after 2 of 6 samples → 2 writes, no done, IDLE.
  - rst low mid-capture → all outputs 0 immediately.
  - A re-arm after either restarts at the new base.
